// File: rtl/sram_responder.sv
// Memory-side responder for the core's inst/data SRAM ports: dual-port word RAM
// with one-cycle read latency plus a small config-register window on the data port.
module sram_responder #(
    parameter int          AW        = 14,
    parameter logic [15:0] CONF_BASE = 16'hBFAF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out
);

    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_SWITCH  = 16'hF004;
    localparam logic [15:0] OFF_TIMER   = 16'hE000;
    localparam logic [15:0] OFF_SCRATCH = 16'hF010;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] inst_idx;
    logic [AW-1:0] data_idx;
    logic [15:0]   conf_off;
    logic          conf_hit;
    logic          data_rd;
    logic          data_wr;
    logic          conf_wr;
    logic          ram_wr;
    logic [31:0]   timer;
    logic [31:0]   scratch;
    logic [31:0]   conf_rdata;
    logic [31:0]   timer_wr_val;
    logic [31:0]   scratch_wr_val;
    logic          unused_bits;

    assign inst_idx = inst_sram_addr[AW+1:2];
    assign data_idx = data_sram_addr[AW+1:2];
    assign conf_off = data_sram_addr[15:0];
    assign conf_hit = data_sram_en && (data_sram_addr[31:16] == CONF_BASE);
    assign data_rd  = data_sram_en && (data_sram_wen == 4'b0000);
    assign data_wr  = data_sram_en && (data_sram_wen != 4'b0000);
    assign conf_wr  = data_wr && conf_hit;
    assign ram_wr   = data_wr && !conf_hit;

    assign unused_bits = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr[31:AW+2],
                           inst_sram_addr[1:0], data_sram_addr[1:0]};

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  wen);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    assign timer_wr_val   = lane_merge(timer, data_sram_wdata, data_sram_wen);
    assign scratch_wr_val = lane_merge(scratch, data_sram_wdata, data_sram_wen);

    always_comb begin
        conf_rdata = 32'h0;
        case (conf_off)
            OFF_LED:     conf_rdata = {16'h0, led_out};
            OFF_SWITCH:  conf_rdata = {16'h0, switch_in};
            OFF_TIMER:   conf_rdata = timer;
            OFF_SCRATCH: conf_rdata = scratch;
            default:     conf_rdata = 32'h0;
        endcase
    end

    // RAM array carries no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Non-blocking reads of mem give read-first behaviour against the data-port write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
            led_out         <= 16'h0;
            timer           <= 32'h0;
            scratch         <= 32'h0;
        end else begin
            if (inst_sram_en) inst_sram_rdata <= mem[inst_idx];
            if (data_rd) data_sram_rdata <= conf_hit ? conf_rdata : mem[data_idx];

            if (conf_wr && conf_off == OFF_TIMER) timer <= timer_wr_val;
            else                                  timer <= timer + 32'd1;

            if (conf_wr && conf_off == OFF_LED) begin
                led_out <= {data_sram_wen[1] ? data_sram_wdata[15:8] : led_out[15:8],
                            data_sram_wen[0] ? data_sram_wdata[7:0]  : led_out[7:0]};
            end

            if (conf_wr && conf_off == OFF_SCRATCH) scratch <= scratch_wr_val;
        end
    end

endmodule
